// File: rtl/serial_in.sv
// serial_in: variable-rate serial link receiver, LSB first, pattern-timed.
// Define SERIAL_IN_MAJORITY_VOTE_EN for 3-sample majority bit decisions.
module serial_in #(
  parameter int DATA_BIT    = 32,
  parameter int LOW_PERIOD  = 200,
  parameter int HIGH_PERIOD = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_mode,
  input  logic [DATA_BIT-1:0] i_freq_pattern,
  input  logic                i_serial_in,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_done_tick,
  output logic                o_bit_tick,
  output logic                o_busy
);

  localparam int IW = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam logic [7:0] LMAX = 8'(LOW_PERIOD - 1);
  localparam logic [7:0] HMAX = 8'(HIGH_PERIOD - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECEIVE,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [DATA_BIT-1:0] freq_q, freq_d;
  logic [DATA_BIT-1:0] buf_q, buf_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cmax_q, cmax_d;
  logic [IW-1:0] idx_q, idx_d;
  logic done_q, done_d;
  logic bit_q, bit_d;
  logic busy_q, busy_d;

  logic [7:0] mid;
  logic [IW-1:0] nidx;
  logic at_max;
  logic last;

  assign mid    = cmax_q >> 1;
  assign nidx   = idx_q + IW'(1);
  assign at_max = (cnt_q == cmax_q);
  assign last   = (idx_q == LAST);

  function automatic logic [7:0] per_max(input logic f);
    return f ? HMAX : LMAX;
  endfunction

`ifdef SERIAL_IN_MAJORITY_VOTE_EN
  logic [1:0] smp_q, smp_d;
  logic maj;
  assign maj = (smp_q[0] & smp_q[1]) |
               (smp_q[0] & i_serial_in) |
               (smp_q[1] & i_serial_in);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      freq_q  <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      cmax_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      bit_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SERIAL_IN_MAJORITY_VOTE_EN
      smp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      cmax_q  <= cmax_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
`ifdef SERIAL_IN_MAJORITY_VOTE_EN
      smp_q   <= smp_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    buf_d   = buf_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    cmax_d  = cmax_q;
    idx_d   = idx_q;
`ifdef SERIAL_IN_MAJORITY_VOTE_EN
    smp_d   = smp_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RECEIVE;
          freq_d  = i_freq_pattern;
          buf_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          cmax_d  = per_max(i_freq_pattern[0]);
        end
      end
      S_RECEIVE: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end else if (at_max) begin
          cnt_d = '0;
          if (last) begin
            state_d = S_DONE;
            data_d  = buf_q;
          end else begin
            idx_d  = nidx;
            cmax_d = per_max(freq_q[nidx]);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
`ifdef SERIAL_IN_MAJORITY_VOTE_EN
          if (cnt_q == mid - 8'd1) smp_d[0] = i_serial_in;
          if (cnt_q == mid) smp_d[1] = i_serial_in;
          if (cnt_q == mid + 8'd1) buf_d[idx_q] = maj;
`else
          if (cnt_q == mid) buf_d[idx_q] = i_serial_in;
`endif
        end
      end
      S_DONE: begin
        // repeat mode restarts after a single gap cycle
        if (i_stop || !i_mode) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RECEIVE;
          freq_d  = i_freq_pattern;
          buf_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          cmax_d  = per_max(i_freq_pattern[0]);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bit_d  = (state_q == S_RECEIVE) && !i_stop && at_max;
    done_d = bit_d && last;
    busy_d = (state_d != S_IDLE);
  end

  assign o_data      = data_q;
  assign o_done_tick = done_q;
  assign o_bit_tick  = bit_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_serial_in.sv
// tb_serial_in: directed vector table plus reset sequences for serial_in.
// Line stimulus comes from a per-edge lane built from freq/data patterns.
module tb_serial_in;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_mode = 1'b0;
  logic [31:0] i_freq_pattern = '0;
  logic        i_serial_in = 1'b0;
  logic [31:0] o_data;
  logic        o_done_tick;
  logic        o_bit_tick;
  logic        o_busy;

  int n_chk = 0;
  int n_fail = 0;

  logic lane [0:8191];

  typedef struct {
    logic        mode;
    logic [31:0] freq;
    logic [31:0] d0;
    logic [31:0] d1;
    int          frames;
    int          run;
    int          stop_at;
    int          start_at;
    int          mode_off;
    int          glitch_at;
    int          exp_ndone;
    int          exp_at0;
    logic [31:0] exp_q0;
    int          exp_at1;
    logic [31:0] exp_q1;
    int          exp_bits;
    int          exp_last_busy;
    logic [31:0] exp_final;
  } vec_t;

  vec_t vecs [6];

  serial_in #(
    .DATA_BIT   (32),
    .LOW_PERIOD (200),
    .HIGH_PERIOD(50)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_mode        (i_mode),
    .i_freq_pattern(i_freq_pattern),
    .i_serial_in   (i_serial_in),
    .o_data        (o_data),
    .o_done_tick   (o_done_tick),
    .o_bit_tick    (o_bit_tick),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_frame(input int s, input logic [31:0] f,
                           input logic [31:0] d, output int e);
    int t;
    t = s;
    for (int k = 0; k < 32; k++) begin
      int p;
      p = f[k] ? 50 : 200;
      for (int j = 1; j <= p; j++) lane[t + j] = d[k];
      t += p;
    end
    e = t;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int e, e2, ndone, nbits, last_busy;
    int at [2];
    logic [31:0] dat [2];
    for (int i = 0; i < 8192; i++) lane[i] = 1'b0;
    add_frame(0, v.freq, v.d0, e);
    if (v.frames == 2) add_frame(e + 1, v.freq, v.d1, e2);
    if (v.glitch_at > 0) lane[v.glitch_at] = ~lane[v.glitch_at];
    ndone = 0;
    nbits = 0;
    last_busy = 0;
    at[0] = -1;
    at[1] = -1;
    dat[0] = '0;
    dat[1] = '0;
    @(negedge clk);
    i_mode = v.mode;
    i_freq_pattern = v.freq;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_serial_in = lane[1];
    for (int n = 1; n <= v.run; n++) begin
      @(posedge clk);
      #1;
      if (o_done_tick) begin
        if (ndone < 2) begin
          at[ndone] = n;
          dat[ndone] = o_data;
        end
        ndone++;
      end
      if (o_bit_tick) nbits++;
      if (o_busy) last_busy = n;
      i_start = (n + 1 == v.start_at);
      i_stop = (n + 1 == v.stop_at);
      if (n + 1 == v.mode_off) i_mode = 1'b0;
      i_serial_in = lane[n + 1];
    end
    i_start = 1'b0;
    i_stop = 1'b0;
    i_mode = 1'b0;
    chk($sformatf("v%0d_ndone", id), 64'(ndone), 64'(v.exp_ndone));
    if (v.exp_ndone >= 1) begin
      chk($sformatf("v%0d_done0_cycle", id), 64'(at[0]), 64'(v.exp_at0));
      chk($sformatf("v%0d_done0_data", id), 64'(dat[0]), 64'(v.exp_q0));
    end
    if (v.exp_ndone >= 2) begin
      chk($sformatf("v%0d_done1_cycle", id), 64'(at[1]), 64'(v.exp_at1));
      chk($sformatf("v%0d_done1_data", id), 64'(dat[1]), 64'(v.exp_q1));
    end
    chk($sformatf("v%0d_bit_ticks", id), 64'(nbits), 64'(v.exp_bits));
    chk($sformatf("v%0d_last_busy", id), 64'(last_busy),
        64'(v.exp_last_busy));
    chk($sformatf("v%0d_final_data", id), 64'(o_data), 64'(v.exp_final));
  endtask

  initial begin
    logic [31:0] glitch_exp;
`ifdef SERIAL_IN_MAJORITY_VOTE_EN
    glitch_exp = 32'hA5A5_0F0F;
`else
    glitch_exp = 32'hA5A5_0F2F;
`endif
    // one-shot, all low rate
    vecs[0] = '{1'b0, 32'h0000_0000, 32'hA5A5_0F0F, 32'h0, 1, 6405,
                0, 0, 0, 0, 1, 6400, 32'hA5A5_0F0F, 0, 32'h0,
                32, 6400, 32'hA5A5_0F0F};
    // mixed rate
    vecs[1] = '{1'b0, 32'h0000_FFFF, 32'h1234_5678, 32'h0, 1, 4005,
                0, 0, 0, 0, 1, 4000, 32'h1234_5678, 0, 32'h0,
                32, 4000, 32'h1234_5678};
    // repeat mode, two frames with one-cycle gap
    vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2, 3210,
                0, 0, 2000, 0, 2, 1600, 32'hDEAD_BEEF, 3201, 32'hCAFE_F00D,
                64, 3201, 32'hCAFE_F00D};
    // abort at cycle 3000
    vecs[3] = '{1'b0, 32'h0000_0000, 32'h0BAD_F00D, 32'h0, 1, 3010,
                3000, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0,
                14, 2999, 32'hCAFE_F00D};
    // full frame after abort, start pulsed while busy
    vecs[4] = '{1'b0, 32'h0F0F_0F0F, 32'h600D_CAFE, 32'h0, 1, 4005,
                0, 500, 0, 0, 1, 4000, 32'h600D_CAFE, 0, 32'h0,
                32, 4000, 32'h600D_CAFE};
    // single-cycle glitch at the mid sample of bit 5
    vecs[5] = '{1'b0, 32'h0000_0000, 32'hA5A5_0F0F, 32'h0, 1, 6405,
                0, 0, 0, 1100, 1, 6400, glitch_exp, 0, 32'h0,
                32, 6400, glitch_exp};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 64'(o_data), 64'h0);
    chk("rst_done", 64'(o_done_tick), 64'h0);
    chk("rst_bit", 64'(o_bit_tick), 64'h0);
    chk("rst_busy", 64'(o_busy), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // reset mid-frame, landing on a bit-end edge
    @(negedge clk);
    i_freq_pattern = 32'h0;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    for (int n = 1; n < 399; n++) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(o_busy), 64'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_data", 64'(o_data), 64'h0);
    chk("mid_rst_done", 64'(o_done_tick), 64'h0);
    chk("mid_rst_bit", 64'(o_bit_tick), 64'h0);
    chk("mid_rst_busy", 64'(o_busy), 64'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_busy", 64'(o_busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
